alarm_fsm: RTL and testbench
============================

ALARM_FSM -- requirements
Module: alarm_fsm

Interface
REQ-001 Parameter T_ARM_DELAY_DEF, 4'd6, default arming delay (s).
REQ-002 Parameter T_DRIVER_DEF, 4'd8, default driver-door countdown (s).
REQ-003 Parameter T_PASSENGER_DEF, 4'd15, default passenger-door countdown (s).
REQ-004 Parameter T_ALARM_ON_DEF, 4'd10, default siren duration (s).
REQ-005 Clock: clock; reset: reset, asynchronous, active-high.
REQ-006 Port: clock  in  1  system clock.
REQ-007 Port: reset  in  1  async active-high reset.
REQ-008 Port: ignition  in  1  1 = ignition on.
REQ-009 Port: door_driver  in  1  1 = driver door open.
REQ-010 Port: door_pass  in  1  1 = passenger door open.
REQ-011 Port: reprogram  in  1  1-cycle pulse, write time_value into selected parameter.
REQ-012 Port: time_param_sel  in  2  00 arm_delay, 01 driver, 10 passenger, 11 alarm_on.
REQ-013 Port: time_value  in  4  new parameter value, seconds.
REQ-014 Port: expired  in  1  countdown timer at zero.
REQ-015 Port: start_timer  out  1  1-cycle load pulse to timer.
REQ-016 Port: interval  out  4  seconds value presented to timer.
REQ-017 Port: siren  out  1  siren drive.
REQ-018 Port: status_led  out  1  status indicator.
REQ-019 Port: fsm_state  out  3  current state code.

Function
REQ-020 States/codes: ARMED 0, TRIGGERED 1, SOUND_ALARM 2, DISARMED 3, WAIT_DRIVER_OPEN 4, WAIT_DRIVER_CLOSE 5, ARM_DELAY 6; codes 7 -> ARMED next cycle.
REQ-021 All outputs registered; state change and matching start_timer/interval appear on the same edge.
REQ-022 start_timer high exactly one cycle per countdown start; interval holds value from that cycle until next start.
REQ-023 expired SHALL be ignored in any cycle where start_timer=1 (timer still stale); valid from the following cycle.
REQ-024 ARMED: ignition -> DISARMED; else door_driver -> TRIGGERED, start T_DRIVER; else door_pass -> TRIGGERED, start T_PASSENGER.
REQ-025 TRIGGERED: ignition -> DISARMED; else expired -> SOUND_ALARM, start T_ALARM_ON.
REQ-026 SOUND_ALARM: ignition -> DISARMED; else expired with any door open -> stay, restart T_ALARM_ON; expired with both closed -> ARMED.
REQ-027 DISARMED: ignition=0 -> WAIT_DRIVER_OPEN.
REQ-028 WAIT_DRIVER_OPEN: ignition -> DISARMED; else door_driver -> WAIT_DRIVER_CLOSE.
REQ-029 WAIT_DRIVER_CLOSE: ignition -> DISARMED; else door_driver=0 and door_pass=0 -> ARM_DELAY, start T_ARM_DELAY.
REQ-030 ARM_DELAY: ignition -> DISARMED; else any door open -> WAIT_DRIVER_CLOSE; else expired -> ARMED.
REQ-031 Priority per cycle: reset > reprogram > ignition > doors > expired.
REQ-032 reprogram: writes time_value to selected register, forces ARMED next cycle, no start_timer issued.
REQ-033 time_value 0 stored as 0; countdown of 0 expires first valid cycle (2 cycles after start).
REQ-034 siren = 1 only in SOUND_ALARM.
REQ-035 status_led = 1 in ARMED, TRIGGERED, SOUND_ALARM; 0 otherwise.

Reset
REQ-036 Reset: state ARMED, start_timer 0, interval 0, siren 0, status_led 1, fsm_state 0.
REQ-037 Reset loads parameter registers with *_DEF values; reset mid-countdown aborts it, no start pulse emitted.

Structure
REQ-038 Package alarm_pkg: state codes, time_param_sel codes, default constants.
REQ-039 Sub-module alarm_param_bank: 4x4-bit register file, async reset to defaults, one write port, four read values.

Verification
REQ-040 Bench uses behavioral timer (1 s = 10 cycles) wired to start_timer/interval/expired.
REQ-041 Reset, door_driver=1 -> TRIGGERED, interval 8; door held, 80+ cycles -> SOUND_ALARM, interval 10, siren 1.
REQ-042 ARMED, door_pass=1 only -> interval 15; ignition=1 during TRIGGERED -> DISARMED, siren 0, led 0.
REQ-043 SOUND_ALARM, door open at expiry -> second start pulse, interval 10; door closed at next expiry -> ARMED.
REQ-044 Disarm path: ignition 1->0, driver open, close -> ARM_DELAY interval 6; reopen at 3 s -> WAIT_DRIVER_CLOSE; close, 60 cycles -> ARMED.
REQ-045 reprogram sel=01 value=3 in TRIGGERED -> ARMED, no pulse; next driver trigger interval 3; value=0 -> SOUND_ALARM 2 cycles after start.

Source files
------------

// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared definitions for the vehicle alarm controller: state
//                codes, time-parameter select codes and default countdowns.
//  Revision    : 1.0  initial release
// ============================================================================
package alarm_pkg;

    typedef logic [2:0] state_t;

    // State codes. They appear on the fsm_state output, so they are fixed.
    localparam state_t c_st_armed             = 3'd0;
    localparam state_t c_st_triggered         = 3'd1;
    localparam state_t c_st_sound_alarm       = 3'd2;
    localparam state_t c_st_disarmed          = 3'd3;
    localparam state_t c_st_wait_driver_open  = 3'd4;
    localparam state_t c_st_wait_driver_close = 3'd5;
    localparam state_t c_st_arm_delay         = 3'd6;

    // time_param_sel codes
    localparam logic [1:0] c_sel_arm_delay = 2'b00;
    localparam logic [1:0] c_sel_driver    = 2'b01;
    localparam logic [1:0] c_sel_passenger = 2'b10;
    localparam logic [1:0] c_sel_alarm_on  = 2'b11;

    // Default countdowns, seconds
    localparam logic [3:0] c_t_arm_delay_def = 4'd6;
    localparam logic [3:0] c_t_driver_def    = 4'd8;
    localparam logic [3:0] c_t_passenger_def = 4'd15;
    localparam logic [3:0] c_t_alarm_on_def  = 4'd10;

    // Status LED is lit whenever the vehicle is guarded.
    function automatic logic led_for_state(input state_t st);
        return (st == c_st_armed) || (st == c_st_triggered) ||
               (st == c_st_sound_alarm);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_param_bank.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_param_bank
//  Description : 4 x 4-bit register file holding the alarm countdown values.
//                One write port, all four values readable at once.
//  Ports       : clock, reset (async, active-high)
//                wr_en / wr_sel[1:0] / wr_data[3:0]  write port
//                t_arm_delay, t_driver, t_passenger, t_alarm_on  read values
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_param_bank
    import alarm_pkg::*;
#(
    parameter logic [3:0] T_ARM_DELAY_DEF = c_t_arm_delay_def,
    parameter logic [3:0] T_DRIVER_DEF    = c_t_driver_def,
    parameter logic [3:0] T_PASSENGER_DEF = c_t_passenger_def,
    parameter logic [3:0] T_ALARM_ON_DEF  = c_t_alarm_on_def
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [3:0] wr_data,
    output logic [3:0] t_arm_delay,
    output logic [3:0] t_driver,
    output logic [3:0] t_passenger,
    output logic [3:0] t_alarm_on
);

    logic [3:0] r_arm_delay;
    logic [3:0] r_driver;
    logic [3:0] r_passenger;
    logic [3:0] r_alarm_on;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_arm_delay <= T_ARM_DELAY_DEF;
            r_driver    <= T_DRIVER_DEF;
            r_passenger <= T_PASSENGER_DEF;
            r_alarm_on  <= T_ALARM_ON_DEF;
        end else if (wr_en) begin
            case (wr_sel)
                c_sel_arm_delay: r_arm_delay <= wr_data;
                c_sel_driver:    r_driver    <= wr_data;
                c_sel_passenger: r_passenger <= wr_data;
                default:         r_alarm_on  <= wr_data;
            endcase
        end
    end

    assign t_arm_delay = r_arm_delay;
    assign t_driver    = r_driver;
    assign t_passenger = r_passenger;
    assign t_alarm_on  = r_alarm_on;

endmodule
`default_nettype wire

// File: rtl/alarm_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_fsm
//  Description : Vehicle anti-theft alarm controller. Drives an external
//                countdown timer (start_timer/interval, expired back) and the
//                siren / status LED. All outputs are registered.
//  Ports       : clock, reset (async, active-high)
//                ignition, door_driver, door_pass      vehicle inputs
//                reprogram, time_param_sel, time_value countdown programming
//                expired                               timer at zero
//                start_timer, interval                 timer load interface
//                siren, status_led, fsm_state          indicators
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_fsm
    import alarm_pkg::*;
#(
    parameter logic [3:0] T_ARM_DELAY_DEF = 4'd6,
    parameter logic [3:0] T_DRIVER_DEF    = 4'd8,
    parameter logic [3:0] T_PASSENGER_DEF = 4'd15,
    parameter logic [3:0] T_ALARM_ON_DEF  = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] interval,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] fsm_state
);

    logic [3:0] w_t_arm_delay;
    logic [3:0] w_t_driver;
    logic [3:0] w_t_passenger;
    logic [3:0] w_t_alarm_on;

    alarm_param_bank #(
        .T_ARM_DELAY_DEF (T_ARM_DELAY_DEF),
        .T_DRIVER_DEF    (T_DRIVER_DEF),
        .T_PASSENGER_DEF (T_PASSENGER_DEF),
        .T_ALARM_ON_DEF  (T_ALARM_ON_DEF)
    ) u_param_bank (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (reprogram),
        .wr_sel      (time_param_sel),
        .wr_data     (time_value),
        .t_arm_delay (w_t_arm_delay),
        .t_driver    (w_t_driver),
        .t_passenger (w_t_passenger),
        .t_alarm_on  (w_t_alarm_on)
    );

    state_t     r_state;
    logic       r_start_timer;
    logic [3:0] r_interval;
    logic       r_siren;
    logic       r_status_led;

    state_t     w_next_state;
    logic       w_start;
    logic [3:0] w_next_interval;
    logic       w_expired_valid;
    logic       w_any_door;

    // While the load pulse is on the wire the timer has not yet reloaded,
    // so its expired flag still reflects the previous countdown.
    assign w_expired_valid = expired & ~r_start_timer;
    assign w_any_door      = door_driver | door_pass;

    always_comb begin
        w_next_state    = r_state;
        w_start         = 1'b0;
        w_next_interval = r_interval;

        if (reprogram) begin
            w_next_state = c_st_armed;
        end else begin
            case (r_state)
                c_st_armed: begin
                    if (ignition) begin
                        w_next_state = c_st_disarmed;
                    end else if (door_driver) begin
                        w_next_state    = c_st_triggered;
                        w_start         = 1'b1;
                        w_next_interval = w_t_driver;
                    end else if (door_pass) begin
                        w_next_state    = c_st_triggered;
                        w_start         = 1'b1;
                        w_next_interval = w_t_passenger;
                    end
                end
                c_st_triggered: begin
                    if (ignition) begin
                        w_next_state = c_st_disarmed;
                    end else if (w_expired_valid) begin
                        w_next_state    = c_st_sound_alarm;
                        w_start         = 1'b1;
                        w_next_interval = w_t_alarm_on;
                    end
                end
                c_st_sound_alarm: begin
                    if (ignition) begin
                        w_next_state = c_st_disarmed;
                    end else if (w_expired_valid) begin
                        if (w_any_door) begin
                            // Keep sounding while a door is still open.
                            w_start         = 1'b1;
                            w_next_interval = w_t_alarm_on;
                        end else begin
                            w_next_state = c_st_armed;
                        end
                    end
                end
                c_st_disarmed: begin
                    if (!ignition) begin
                        w_next_state = c_st_wait_driver_open;
                    end
                end
                c_st_wait_driver_open: begin
                    if (ignition) begin
                        w_next_state = c_st_disarmed;
                    end else if (door_driver) begin
                        w_next_state = c_st_wait_driver_close;
                    end
                end
                c_st_wait_driver_close: begin
                    if (ignition) begin
                        w_next_state = c_st_disarmed;
                    end else if (!w_any_door) begin
                        w_next_state    = c_st_arm_delay;
                        w_start         = 1'b1;
                        w_next_interval = w_t_arm_delay;
                    end
                end
                c_st_arm_delay: begin
                    if (ignition) begin
                        w_next_state = c_st_disarmed;
                    end else if (w_any_door) begin
                        w_next_state = c_st_wait_driver_close;
                    end else if (w_expired_valid) begin
                        w_next_state = c_st_armed;
                    end
                end
                default: begin
                    w_next_state = c_st_armed;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_armed;
            r_start_timer <= 1'b0;
            r_interval    <= 4'd0;
            r_siren       <= 1'b0;
            r_status_led  <= 1'b1;
        end else begin
            r_state       <= w_next_state;
            r_start_timer <= w_start;
            r_interval    <= w_next_interval;
            r_siren       <= (w_next_state == c_st_sound_alarm);
            r_status_led  <= led_for_state(w_next_state);
        end
    end

    assign start_timer = r_start_timer;
    assign interval    = r_interval;
    assign siren       = r_siren;
    assign status_led  = r_status_led;
    assign fsm_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_fsm
//  Description : Directed self-checking bench for alarm_fsm with a
//                behavioural countdown timer (1 s = 10 clock cycles).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       ignition;
    logic       door_driver;
    logic       door_pass;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired;
    logic       start_timer;
    logic [3:0] interval;
    logic       siren;
    logic       status_led;
    logic [2:0] fsm_state;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clock = ~clock;

    alarm_fsm dut (
        .clock          (clock),
        .reset          (reset),
        .ignition       (ignition),
        .door_driver    (door_driver),
        .door_pass      (door_pass),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .expired        (expired),
        .start_timer    (start_timer),
        .interval       (interval),
        .siren          (siren),
        .status_led     (status_led),
        .fsm_state      (fsm_state)
    );

    // Behavioural countdown timer: loads interval*10 on a start pulse.
    logic [7:0] tmr_count;
    always @(posedge clock or posedge reset) begin
        if (reset)                tmr_count <= 8'd0;
        else if (start_timer)     tmr_count <= {4'd0, interval} * 8'd10;
        else if (tmr_count != 0)  tmr_count <= tmr_count - 8'd1;
    end
    assign expired = (tmr_count == 8'd0);

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Ticks until fsm_state equals target; n counts ticks taken.
    task automatic wait_state(input logic [2:0] target, input int limit);
        n = 0;
        while (fsm_state !== target && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_start(input int limit);
        n = 0;
        do begin
            tick();
            n++;
        end while (start_timer !== 1'b1 && n < limit);
    endtask

    task automatic test_reset();
        reset = 1'b0; ignition = 0; door_driver = 0; door_pass = 0;
        reprogram = 0; time_param_sel = 2'b00; time_value = 4'd0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", fsm_state); end
        checks++; if (start_timer !== 1'b0) begin errors++; $display("FAIL rst_start got %0b exp 0", start_timer); end
        checks++; if (interval !== 4'd0) begin errors++; $display("FAIL rst_interval got %0d exp 0", interval); end
        checks++; if (siren !== 1'b0) begin errors++; $display("FAIL rst_siren got %0b exp 0", siren); end
        checks++; if (status_led !== 1'b1) begin errors++; $display("FAIL rst_led got %0b exp 1", status_led); end
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL post_rst_state got %0d exp 0", fsm_state); end
    endtask

    task automatic test_driver_trigger();
        door_driver = 1'b1;
        tick();
        checks++; if (fsm_state !== 3'd1) begin errors++; $display("FAIL drv_state got %0d exp 1", fsm_state); end
        checks++; if (start_timer !== 1'b1) begin errors++; $display("FAIL drv_start got %0b exp 1", start_timer); end
        checks++; if (interval !== 4'd8) begin errors++; $display("FAIL drv_interval got %0d exp 8", interval); end
        tick();
        checks++; if (start_timer !== 1'b0) begin errors++; $display("FAIL drv_pulse_width got %0b exp 0", start_timer); end
        n = 1;
        while (fsm_state !== 3'd2 && n < 200) begin tick(); n++; end
        checks++; if (n !== 82) begin errors++; $display("FAIL drv_to_sound cycles got %0d exp 82", n); end
        checks++; if (interval !== 4'd10 || start_timer !== 1'b1) begin errors++; $display("FAIL sound_start got int=%0d st=%0b exp int=10 st=1", interval, start_timer); end
        checks++; if (siren !== 1'b1 || status_led !== 1'b1) begin errors++; $display("FAIL sound_outputs got siren=%0b led=%0b exp 1 1", siren, status_led); end
    endtask

    task automatic test_sound_restart();
        wait_start(300);
        checks++; if (n !== 102) begin errors++; $display("FAIL restart cycles got %0d exp 102", n); end
        checks++; if (fsm_state !== 3'd2 || interval !== 4'd10) begin errors++; $display("FAIL restart got state=%0d int=%0d exp 2 10", fsm_state, interval); end
        door_driver = 1'b0;
        tick();
        checks++; if (start_timer !== 1'b0 || siren !== 1'b1) begin errors++; $display("FAIL restart_hold got st=%0b siren=%0b exp 0 1", start_timer, siren); end
        n = 1;
        while (fsm_state !== 3'd0 && n < 300) begin tick(); n++; end
        checks++; if (n !== 102) begin errors++; $display("FAIL sound_to_armed cycles got %0d exp 102", n); end
        checks++; if (siren !== 1'b0 || status_led !== 1'b1 || start_timer !== 1'b0) begin errors++; $display("FAIL armed_outputs got siren=%0b led=%0b st=%0b exp 0 1 0", siren, status_led, start_timer); end
    endtask

    task automatic test_pass_trigger();
        door_pass = 1'b1;
        tick();
        checks++; if (fsm_state !== 3'd1 || interval !== 4'd15 || start_timer !== 1'b1) begin errors++; $display("FAIL pass_trig got state=%0d int=%0d st=%0b exp 1 15 1", fsm_state, interval, start_timer); end
        door_pass = 1'b0;
        repeat (3) tick();
        checks++; if (fsm_state !== 3'd1) begin errors++; $display("FAIL pass_hold got %0d exp 1", fsm_state); end
        ignition = 1'b1;
        tick();
        checks++; if (fsm_state !== 3'd3 || siren !== 1'b0 || status_led !== 1'b0) begin errors++; $display("FAIL disarm got state=%0d siren=%0b led=%0b exp 3 0 0", fsm_state, siren, status_led); end
    endtask

    task automatic test_disarm_path();
        ignition = 1'b0;
        tick();
        checks++; if (fsm_state !== 3'd4) begin errors++; $display("FAIL wdo got %0d exp 4", fsm_state); end
        tick();
        checks++; if (fsm_state !== 3'd4) begin errors++; $display("FAIL wdo_hold got %0d exp 4", fsm_state); end
        door_driver = 1'b1;
        tick();
        checks++; if (fsm_state !== 3'd5) begin errors++; $display("FAIL wdc got %0d exp 5", fsm_state); end
        door_driver = 1'b0;
        tick();
        checks++; if (fsm_state !== 3'd6 || interval !== 4'd6 || start_timer !== 1'b1 || status_led !== 1'b0) begin errors++; $display("FAIL arm_delay got state=%0d int=%0d st=%0b led=%0b exp 6 6 1 0", fsm_state, interval, start_timer, status_led); end
        repeat (30) tick();
        checks++; if (fsm_state !== 3'd6) begin errors++; $display("FAIL arm_delay_hold got %0d exp 6", fsm_state); end
        door_driver = 1'b1;
        tick();
        checks++; if (fsm_state !== 3'd5) begin errors++; $display("FAIL reopen got %0d exp 5", fsm_state); end
        door_driver = 1'b0;
        tick();
        checks++; if (fsm_state !== 3'd6 || start_timer !== 1'b1) begin errors++; $display("FAIL rearm got state=%0d st=%0b exp 6 1", fsm_state, start_timer); end
        n = 0;
        while (fsm_state !== 3'd0 && n < 200) begin tick(); n++; end
        checks++; if (n !== 62) begin errors++; $display("FAIL arm_delay_cycles got %0d exp 62", n); end
        checks++; if (status_led !== 1'b1 || start_timer !== 1'b0) begin errors++; $display("FAIL armed_again got led=%0b st=%0b exp 1 0", status_led, start_timer); end
    endtask

    task automatic test_reprogram();
        door_driver = 1'b1;
        tick();
        checks++; if (fsm_state !== 3'd1 || interval !== 4'd8) begin errors++; $display("FAIL rp_trig got state=%0d int=%0d exp 1 8", fsm_state, interval); end
        door_driver = 1'b0;
        tick();
        // ignition asserted alongside: reprogram must win
        reprogram = 1'b1; time_param_sel = 2'b01; time_value = 4'd3; ignition = 1'b1;
        tick();
        reprogram = 1'b0; ignition = 1'b0;
        checks++; if (fsm_state !== 3'd0 || start_timer !== 1'b0 || interval !== 4'd8) begin errors++; $display("FAIL rp_force got state=%0d st=%0b int=%0d exp 0 0 8", fsm_state, start_timer, interval); end
        tick();
        checks++; if (fsm_state !== 3'd0 || start_timer !== 1'b0) begin errors++; $display("FAIL rp_idle got state=%0d st=%0b exp 0 0", fsm_state, start_timer); end
        door_driver = 1'b1;
        tick();
        checks++; if (fsm_state !== 3'd1 || interval !== 4'd3 || start_timer !== 1'b1) begin errors++; $display("FAIL rp_new_int got state=%0d int=%0d st=%0b exp 1 3 1", fsm_state, interval, start_timer); end
        n = 0;
        while (fsm_state !== 3'd2 && n < 200) begin tick(); n++; end
        checks++; if (n !== 32) begin errors++; $display("FAIL rp3_cycles got %0d exp 32", n); end
        reprogram = 1'b1; time_param_sel = 2'b01; time_value = 4'd0;
        tick();
        reprogram = 1'b0;
        checks++; if (fsm_state !== 3'd0 || siren !== 1'b0 || start_timer !== 1'b0) begin errors++; $display("FAIL rp_from_sound got state=%0d siren=%0b st=%0b exp 0 0 0", fsm_state, siren, start_timer); end
        tick();
        checks++; if (fsm_state !== 3'd1 || interval !== 4'd0 || start_timer !== 1'b1) begin errors++; $display("FAIL rp_zero got state=%0d int=%0d st=%0b exp 1 0 1", fsm_state, interval, start_timer); end
        n = 0;
        while (fsm_state !== 3'd2 && n < 50) begin tick(); n++; end
        checks++; if (n !== 2) begin errors++; $display("FAIL zero_cycles got %0d exp 2", n); end
        checks++; if (siren !== 1'b1) begin errors++; $display("FAIL zero_siren got %0b exp 1", siren); end
    endtask

    task automatic test_reset_mid();
        repeat (20) tick();
        reset = 1'b1;
        #1;
        checks++; if (fsm_state !== 3'd0 || siren !== 1'b0 || start_timer !== 1'b0 || interval !== 4'd0 || status_led !== 1'b1) begin errors++; $display("FAIL mid_rst got state=%0d siren=%0b st=%0b int=%0d led=%0b exp 0 0 0 0 1", fsm_state, siren, start_timer, interval, status_led); end
        tick(); tick();
        checks++; if (start_timer !== 1'b0) begin errors++; $display("FAIL mid_rst_pulse got %0b exp 0", start_timer); end
        reset = 1'b0;
        tick();
        // door_driver still held: retrigger with default restored
        checks++; if (fsm_state !== 3'd1 || interval !== 4'd8) begin errors++; $display("FAIL default_restore got state=%0d int=%0d exp 1 8", fsm_state, interval); end
        ignition = 1'b1;
        tick();
        checks++; if (fsm_state !== 3'd3) begin errors++; $display("FAIL ign_over_door got %0d exp 3", fsm_state); end
        ignition = 1'b0; door_driver = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_driver_trigger();
        test_sound_restart();
        test_pass_trigger();
        test_disarm_path();
        test_reprogram();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
